// File: rtl/ysyx_22040759_if_axi_bridge_pkg.sv
// rtl/ysyx_22040759_if_axi_bridge_pkg.sv - AXI constants, NOP encoding and FSM states for the fetch bridge
package ysyx_22040759_if_axi_bridge_pkg;

    localparam logic [2:0]  AXI_SIZE_8B     = 3'b011;
    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
    localparam logic [31:0] NOP_ENC         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/ysyx_22040759_if_axi_bridge_if.sv
// rtl/ysyx_22040759_if_axi_bridge_if.sv - single-beat AXI4 read-only bus (AR + R channels)
interface ysyx_22040759_if_axi_bridge_if #(
    parameter int AXI_ID_W = 4
);
    logic                axi_ar_valid;
    logic                axi_ar_ready;
    logic [63:0]         axi_ar_addr;
    logic [AXI_ID_W-1:0] axi_ar_id;
    logic [7:0]          axi_ar_len;
    logic [2:0]          axi_ar_size;
    logic [1:0]          axi_ar_burst;
    logic                axi_r_valid;
    logic                axi_r_ready;
    logic [63:0]         axi_r_data;
    logic [1:0]          axi_r_resp;
    logic                axi_r_last;
    logic [AXI_ID_W-1:0] axi_r_id;

    modport master (
        output axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
        input  axi_ar_ready,
        input  axi_r_valid, axi_r_data, axi_r_resp, axi_r_last, axi_r_id,
        output axi_r_ready
    );

    modport slave (
        input  axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
        output axi_ar_ready,
        output axi_r_valid, axi_r_data, axi_r_resp, axi_r_last, axi_r_id,
        input  axi_r_ready
    );
endinterface

// File: rtl/ysyx_22040759_axi_word_sel.sv
// rtl/ysyx_22040759_axi_word_sel.sv - picks the 32-bit instruction out of a 64-bit beat, NOP on error
module ysyx_22040759_axi_word_sel #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_hi,
    input  logic [63:0] i_data,
    input  logic        i_err,
    output logic [31:0] o_word
);
    assign o_word = i_err ? NOP_INST : (i_hi ? i_data[63:32] : i_data[31:0]);
endmodule

// File: rtl/ysyx_22040759_if_axi_bridge.sv
// rtl/ysyx_22040759_if_axi_bridge.sv - IF fetch request to single-beat AXI4 read bridge
module ysyx_22040759_if_axi_bridge
    import ysyx_22040759_if_axi_bridge_pkg::*;
#(
    parameter int          AXI_ID_W = 4,
    parameter int          AXI_ID   = 0,
    parameter logic [31:0] NOP_INST = NOP_ENC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_if_valid,
    input  logic [63:0] i_inst_addr,
    output logic        o_if_ready,
    output logic [63:0] o_if_data_read,
    output logic        o_if_err,
    ysyx_22040759_if_axi_bridge_if.master axi
);
    state_t      r_state;
    logic [63:0] r_addr_q;
    logic        r_err_q;
    logic        r_ar_valid;
    logic        r_r_ready;
    logic [63:0] r_data_read;

    logic        w_ar_fire;
    logic        w_beat;
    logic        w_beat_err;
    logic        w_match;
    logic [31:0] w_word;
    logic        w_unused;

    assign w_ar_fire  = r_ar_valid && axi.axi_ar_ready;
    // Beats with a foreign ID are still acked via r_ready but never captured.
    assign w_beat     = (r_state == ST_R) && axi.axi_r_valid
                        && (axi.axi_r_id == AXI_ID_W'(AXI_ID));
    assign w_beat_err = resp_is_err(axi.axi_r_resp);
    assign w_match    = i_if_valid && (i_inst_addr == r_addr_q);
    assign w_unused   = axi.axi_r_last;

    ysyx_22040759_axi_word_sel #(
        .NOP_INST (NOP_INST)
    ) u_word_sel (
        .i_hi   (r_addr_q[2]),
        .i_data (axi.axi_r_data),
        .i_err  (w_beat_err),
        .o_word (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr_q    <= 64'd0;
            r_err_q     <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_r_ready   <= 1'b0;
            r_data_read <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_if_valid) begin
                        r_addr_q   <= i_inst_addr;
                        r_ar_valid <= 1'b1;
                        r_state    <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (w_ar_fire) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_R;
                    end
                end
                ST_R: begin
                    if (w_beat) begin
                        r_r_ready   <= 1'b0;
                        r_data_read <= {32'd0, w_word};
                        r_err_q     <= w_beat_err;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The pulse is qualified by the live request so a stale response is silently dropped.
    assign o_if_ready     = (r_state == ST_RESP) && w_match;
    assign o_if_err       = o_if_ready && r_err_q;
    assign o_if_data_read = r_data_read;

    assign axi.axi_ar_valid = r_ar_valid;
    assign axi.axi_ar_addr  = {r_addr_q[63:3], 3'b000};
    assign axi.axi_ar_id    = AXI_ID_W'(AXI_ID);
    assign axi.axi_ar_len   = 8'd0;
    assign axi.axi_ar_size  = AXI_SIZE_8B;
    assign axi.axi_ar_burst = AXI_BURST_INCR;
    assign axi.axi_r_ready  = r_r_ready;
endmodule

// File: tb/tb_ysyx_22040759_if_axi_bridge.sv
// tb/tb_ysyx_22040759_if_axi_bridge.sv - directed self-checking bench for the fetch AXI bridge
module tb_ysyx_22040759_if_axi_bridge;
    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [63:0] inst_addr;
    logic        if_ready;
    logic [63:0] if_data_read;
    logic        if_err;

    int n_checks;
    int n_fail;

    ysyx_22040759_if_axi_bridge_if #(.AXI_ID_W(4)) bus ();

    ysyx_22040759_if_axi_bridge #(
        .AXI_ID_W (4),
        .AXI_ID   (0),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_if_valid     (if_valid),
        .i_inst_addr    (inst_addr),
        .o_if_ready     (if_ready),
        .o_if_data_read (if_data_read),
        .o_if_err       (if_err),
        .axi            (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready got %b exp 0", if_ready); end
        n_checks++; if (if_data_read !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", if_data_read); end
        n_checks++; if (if_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", if_err); end
        n_checks++; if (bus.axi_ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ar_valid got %b exp 0", bus.axi_ar_valid); end
        n_checks++; if (bus.axi_r_ready !== 1'b0) begin n_fail++; $display("FAIL reset_r_ready got %b exp 0", bus.axi_r_ready); end
        n_checks++; if ({bus.axi_ar_len, bus.axi_ar_size, bus.axi_ar_burst, bus.axi_ar_id} !== {8'd0, 3'b011, 2'b01, 4'd0})
            begin n_fail++; $display("FAIL ar_consts got %h %b %b %h", bus.axi_ar_len, bus.axi_ar_size, bus.axi_ar_burst, bus.axi_ar_id); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_fetch;
        bus.axi_ar_ready = 1'b1;
        bus.axi_r_valid  = 1'b1;
        bus.axi_r_data   = 64'h0000_0013_0010_0093;
        bus.axi_r_resp   = 2'b00;
        if_valid  = 1'b1;
        inst_addr = 64'h8000_0000;
        tick();
        n_checks++; if (bus.axi_ar_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ar_valid got %b exp 1", bus.axi_ar_valid); end
        n_checks++; if (bus.axi_ar_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL basic_ar_addr got %h exp 80000000", bus.axi_ar_addr); end
        n_checks++; if (bus.axi_r_ready !== 1'b0) begin n_fail++; $display("FAIL basic_r_ready_in_ar got %b exp 0", bus.axi_r_ready); end
        tick();
        n_checks++; if (bus.axi_r_ready !== 1'b1) begin n_fail++; $display("FAIL basic_r_ready got %b exp 1", bus.axi_r_ready); end
        n_checks++; if (bus.axi_ar_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ar_drop got %b exp 0", bus.axi_ar_valid); end
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL basic_early_ready got %b exp 0", if_ready); end
        tick();
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b exp 1", if_ready); end
        n_checks++; if (if_data_read !== 64'h0000_0000_0010_0093) begin n_fail++; $display("FAIL basic_data got %h exp 00100093", if_data_read); end
        n_checks++; if (if_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b exp 0", if_err); end
        if_valid = 1'b0;
        tick();
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse got %b exp 0", if_ready); end
        n_checks++; if (if_data_read !== 64'h0000_0000_0010_0093) begin n_fail++; $display("FAIL basic_data_hold got %h exp 00100093", if_data_read); end
    endtask

    task automatic test_upper_word;
        if_valid  = 1'b1;
        inst_addr = 64'h8000_0004;
        tick();
        n_checks++; if (bus.axi_ar_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL upper_ar_addr got %h exp 80000000", bus.axi_ar_addr); end
        tick();
        tick();
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL upper_ready got %b exp 1", if_ready); end
        n_checks++; if (if_data_read !== 64'h0000_0000_0000_0013) begin n_fail++; $display("FAIL upper_data got %h exp 13", if_data_read); end
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_ar_wait;
        bus.axi_ar_ready = 1'b0;
        bus.axi_r_data   = 64'hDEAD_BEEF_CAFE_F00D;
        if_valid  = 1'b1;
        inst_addr = 64'h8000_0010;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.axi_ar_valid !== 1'b1 || bus.axi_ar_addr !== 64'h8000_0010)
                begin n_fail++; $display("FAIL arwait_hold[%0d] got valid %b addr %h exp 1 80000010", i, bus.axi_ar_valid, bus.axi_ar_addr); end
            n_checks++; if (bus.axi_r_ready !== 1'b0) begin n_fail++; $display("FAIL arwait_r_ready[%0d] got %b exp 0", i, bus.axi_r_ready); end
            tick();
        end
        bus.axi_ar_ready = 1'b1;
        tick();
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL arwait_early got %b exp 0", if_ready); end
        tick();
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL arwait_ready got %b exp 1", if_ready); end
        n_checks++; if (if_data_read !== 64'h0000_0000_CAFE_F00D) begin n_fail++; $display("FAIL arwait_data got %h exp cafef00d", if_data_read); end
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_error;
        bus.axi_r_resp = 2'b10;
        bus.axi_r_data = 64'h1111_1111_2222_2222;
        if_valid  = 1'b1;
        inst_addr = 64'h8000_0020;
        tick();
        tick();
        tick();
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready got %b exp 1", if_ready); end
        n_checks++; if (if_err !== 1'b1) begin n_fail++; $display("FAIL err_flag got %b exp 1", if_err); end
        n_checks++; if (if_data_read !== 64'h0000_0000_0000_0013) begin n_fail++; $display("FAIL err_data got %h exp 13", if_data_read); end
        if_valid = 1'b0;
        tick();
        n_checks++; if (if_err !== 1'b0 || if_ready !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got err %b ready %b exp 0 0", if_err, if_ready); end
        n_checks++; if (bus.axi_ar_valid !== 1'b0 || bus.axi_r_ready !== 1'b0)
            begin n_fail++; $display("FAIL err_idle got ar_valid %b r_ready %b exp 0 0", bus.axi_ar_valid, bus.axi_r_ready); end
        bus.axi_r_resp = 2'b00;
    endtask

    task automatic test_id_mismatch;
        bus.axi_r_data = 64'h0000_AAAA_0000_BBBB;
        bus.axi_r_id   = 4'h5;
        if_valid  = 1'b1;
        inst_addr = 64'h8000_0030;
        tick();
        tick();
        tick();
        n_checks++; if (bus.axi_r_ready !== 1'b1 || if_ready !== 1'b0)
            begin n_fail++; $display("FAIL id_drop got r_ready %b if_ready %b exp 1 0", bus.axi_r_ready, if_ready); end
        bus.axi_r_id = 4'h0;
        tick();
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL id_ready got %b exp 1", if_ready); end
        n_checks++; if (if_data_read !== 64'h0000_0000_0000_BBBB) begin n_fail++; $display("FAIL id_data got %h exp bbbb", if_data_read); end
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_stale;
        bus.axi_r_valid = 1'b0;
        bus.axi_r_data  = 64'h0000_0000_1234_5678;
        if_valid  = 1'b1;
        inst_addr = 64'h8000_0008;
        tick();
        tick();
        inst_addr       = 64'h8000_0100;
        bus.axi_r_valid = 1'b1;
        tick();
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL stale_no_pulse got %b exp 0", if_ready); end
        tick();
        n_checks++; if (bus.axi_ar_valid !== 1'b0 || if_ready !== 1'b0)
            begin n_fail++; $display("FAIL stale_idle got ar_valid %b if_ready %b exp 0 0", bus.axi_ar_valid, if_ready); end
        tick();
        n_checks++; if (bus.axi_ar_valid !== 1'b1 || bus.axi_ar_addr !== 64'h8000_0100)
            begin n_fail++; $display("FAIL stale_rereq got valid %b addr %h exp 1 80000100", bus.axi_ar_valid, bus.axi_ar_addr); end
        tick();
        tick();
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL stale_new_ready got %b exp 1", if_ready); end
        n_checks++; if (if_data_read !== 64'h0000_0000_1234_5678) begin n_fail++; $display("FAIL stale_new_data got %h exp 12345678", if_data_read); end
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        bus.axi_r_valid = 1'b0;
        bus.axi_r_data  = 64'h0000_0000_0050_0513;
        if_valid  = 1'b1;
        inst_addr = 64'h8000_0040;
        tick();
        tick();
        n_checks++; if (bus.axi_r_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_r got %b exp 1", bus.axi_r_ready); end
        rst = 1'b1;
        tick();
        n_checks++; if (bus.axi_r_ready !== 1'b0 || if_ready !== 1'b0 || bus.axi_ar_valid !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_outputs got r_ready %b if_ready %b ar_valid %b exp 0 0 0", bus.axi_r_ready, if_ready, bus.axi_ar_valid); end
        n_checks++; if (if_data_read !== 64'd0) begin n_fail++; $display("FAIL rstmid_data got %h exp 0", if_data_read); end
        rst = 1'b0;
        bus.axi_r_valid = 1'b1;
        tick();
        n_checks++; if (bus.axi_ar_valid !== 1'b1 || bus.axi_ar_addr !== 64'h8000_0040)
            begin n_fail++; $display("FAIL rstmid_restart got valid %b addr %h exp 1 80000040", bus.axi_ar_valid, bus.axi_ar_addr); end
        tick();
        tick();
        n_checks++; if (if_ready !== 1'b1 || if_data_read !== 64'h0000_0000_0050_0513)
            begin n_fail++; $display("FAIL rstmid_resp got ready %b data %h exp 1 00500513", if_ready, if_data_read); end
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        int first_at;
        int second_at;
        first_at  = -1;
        second_at = -1;
        bus.axi_r_data = 64'h0000_0013_0010_0093;
        if_valid  = 1'b1;
        inst_addr = 64'h8000_0000;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (if_ready === 1'b1) begin
                if (first_at < 0) begin
                    first_at  = c;
                    inst_addr = 64'h8000_0004;
                end else begin
                    second_at = c;
                    if_valid  = 1'b0;
                end
            end
        end
        n_checks++; if (first_at !== 2) begin n_fail++; $display("FAIL b2b_first got %0d exp 2", first_at); end
        n_checks++; if (second_at !== 6) begin n_fail++; $display("FAIL b2b_second got %0d exp 6", second_at); end
        n_checks++; if (if_data_read !== 64'h0000_0000_0000_0013) begin n_fail++; $display("FAIL b2b_data got %h exp 13", if_data_read); end
        if_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst       = 1'b1;
        if_valid  = 1'b0;
        inst_addr = 64'd0;
        bus.axi_ar_ready = 1'b0;
        bus.axi_r_valid  = 1'b0;
        bus.axi_r_data   = 64'd0;
        bus.axi_r_resp   = 2'b00;
        bus.axi_r_last   = 1'b1;
        bus.axi_r_id     = 4'd0;
        test_reset();
        test_basic_fetch();
        test_upper_word();
        test_ar_wait();
        test_error();
        test_id_mismatch();
        test_stale();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
